// File: rtl/seq_input_cond.sv
// seq_input_cond
// ---------------------------------------------------------------------------
// Conditions the raw single-bit control level that feeds the sequence FSM's
// C input. The asynchronous level is brought into the clk domain through a
// SYNC_STAGES-deep flop chain. A four-state debouncer then makes the change
// visible on c_out only after DEBOUNCE_CYCLES consecutive enabled edges
// disagree with the current level.
//
// Parameters
//   SYNC_STAGES      synchroniser depth, 2..4
//   DEBOUNCE_CYCLES  consecutive mismatching samples needed to flip, 1..255
//   RESET_VAL        reset level of c_out and of every synchroniser flop
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   din_async   in   raw asynchronous level
//   en          in   debounce enable; c_out is frozen while low
//   c_out       out  debounced, synchronised level (flop output)
//   rise_pulse  out  one-cycle strobe on the first cycle of c_out = 1
//   fall_pulse  out  one-cycle strobe on the first cycle of c_out = 0
//   state       out  debouncer state for debug:
//                    00 STABLE_LO, 01 CHK_HI, 10 STABLE_HI, 11 CHK_LO
//   glitch_cnt  out  saturating count of rejected glitches
//                    (only when SEQ_INPUT_COND_GLITCH_CNT_EN is defined)
//
// Optional feature macro: SEQ_INPUT_COND_GLITCH_CNT_EN
// ---------------------------------------------------------------------------
module seq_input_cond #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din_async,
  input  logic       en,
  output logic       c_out,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [1:0] state
`ifdef SEQ_INPUT_COND_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHK_HI    = 2'b01,
    STABLE_HI = 2'b10,
    CHK_LO    = 2'b11
  } state_t;

  localparam state_t RESET_STATE = RESET_VAL ? STABLE_HI : STABLE_LO;

  // Synchroniser chain: bit 0 samples the pin, the top bit is sync_q.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din_async};
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  // Debouncer state.
  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_c_out, w_c_out_next;
  logic          r_rise, w_rise_next;
  logic          r_fall, w_fall_next;
  logic          w_glitch;  // sync_q fell back to the c_out level mid-check

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RESET_STATE;
      r_cnt   <= '0;
      r_c_out <= RESET_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_c_out <= w_c_out_next;
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_c_out_next = r_c_out;
    w_rise_next  = 1'b0;
    w_fall_next  = 1'b0;
    w_glitch     = 1'b0;
    unique case (r_state)
      STABLE_LO: begin
        if (en && w_sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_c_out_next = 1'b1;
            w_rise_next  = 1'b1;
            w_state_next = STABLE_HI;
            w_cnt_next   = '0;
          end else begin
            w_state_next = CHK_HI;
            w_cnt_next   = CW'(1);
          end
        end
      end
      CHK_HI: begin
        if (!en) begin
          w_state_next = STABLE_LO;
          w_cnt_next   = '0;
        end else if (!w_sync_q) begin
          w_state_next = STABLE_LO;
          w_cnt_next   = '0;
          w_glitch     = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_c_out_next = 1'b1;
          w_rise_next  = 1'b1;
          w_state_next = STABLE_HI;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      STABLE_HI: begin
        if (en && !w_sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_c_out_next = 1'b0;
            w_fall_next  = 1'b1;
            w_state_next = STABLE_LO;
            w_cnt_next   = '0;
          end else begin
            w_state_next = CHK_LO;
            w_cnt_next   = CW'(1);
          end
        end
      end
      CHK_LO: begin
        if (!en) begin
          w_state_next = STABLE_HI;
          w_cnt_next   = '0;
        end else if (w_sync_q) begin
          w_state_next = STABLE_HI;
          w_cnt_next   = '0;
          w_glitch     = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_c_out_next = 1'b0;
          w_fall_next  = 1'b1;
          w_state_next = STABLE_LO;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = RESET_STATE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign c_out      = r_c_out;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign state      = r_state;

`ifdef SEQ_INPUT_COND_GLITCH_CNT_EN
  logic [7:0] r_glitch_cnt;

  // Saturating: once at 255 further glitches are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_glitch_cnt <= 8'd0;
    end else if (w_glitch && (r_glitch_cnt != 8'hFF)) begin
      r_glitch_cnt <= r_glitch_cnt + 8'd1;
    end
  end

  assign glitch_cnt = r_glitch_cnt;
`else
  logic w_glitch_unused;
  assign w_glitch_unused = w_glitch;
`endif

endmodule

// File: tb/tb_seq_input_cond.sv
// Bench for seq_input_cond. Two instances share the stimulus: one with the
// default parameters and one with DEBOUNCE_CYCLES = 1. A reference model
// tracks, per instance, the run length of consecutive enabled mismatching
// samples and flips its level when the run reaches DEBOUNCE_CYCLES.
module tb_seq_input_cond;

  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst, din_async, en;

  logic       c_out0, rise0, fall0;
  logic [1:0] state0;
  logic       c_out1, rise1, fall1;
  logic [1:0] state1;
`ifdef SEQ_INPUT_COND_GLITCH_CNT_EN
  logic [7:0] gcnt0, gcnt1;
`endif

  always #5 clk = ~clk;

  seq_input_cond #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(4), .RESET_VAL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .din_async(din_async), .en(en),
    .c_out(c_out0), .rise_pulse(rise0), .fall_pulse(fall0), .state(state0)
`ifdef SEQ_INPUT_COND_GLITCH_CNT_EN
    , .glitch_cnt(gcnt0)
`endif
  );

  seq_input_cond #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(1), .RESET_VAL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .din_async(din_async), .en(en),
    .c_out(c_out1), .rise_pulse(rise1), .fall_pulse(fall1), .state(state1)
`ifdef SEQ_INPUT_COND_GLITCH_CNT_EN
    , .glitch_cnt(gcnt1)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model.
  bit hist[$];            // hist[0] = most recently sampled din
  int m_dc[2] = '{4, 1};
  bit m_c[2];
  int m_run[2];
  bit m_rise[2], m_fall[2];
  int m_glitch[2];

  task automatic model_step(input bit r, input bit d, input bit e);
    bit sq;
    if (r) begin
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back(1'b0);
      for (int k = 0; k < 2; k++) begin
        m_c[k] = 1'b0; m_run[k] = 0; m_rise[k] = 1'b0; m_fall[k] = 1'b0; m_glitch[k] = 0;
      end
    end else begin
      sq = hist[SS-1];
      hist.push_front(d);
      hist = hist[0:SS-1];
      for (int k = 0; k < 2; k++) begin
        m_rise[k] = 1'b0;
        m_fall[k] = 1'b0;
        if (!e) begin
          m_run[k] = 0;
        end else if (sq != m_c[k]) begin
          m_run[k]++;
          if (m_run[k] == m_dc[k]) begin
            m_c[k] = ~m_c[k];
            if (m_c[k]) m_rise[k] = 1'b1;
            else        m_fall[k] = 1'b1;
            m_run[k] = 0;
          end
        end else begin
          if (m_run[k] > 0 && m_glitch[k] < 255) m_glitch[k]++;
          m_run[k] = 0;
        end
      end
    end
  endtask

  function automatic logic [1:0] exp_state(input int k);
    // Level in the high bit, "checking" flag in the low bit.
    return {m_c[k], (m_run[k] != 0)};
  endfunction

  task automatic compare_all();
    check_eq("c_out0", c_out0, m_c[0]);
    check_eq("rise0",  rise0,  m_rise[0]);
    check_eq("fall0",  fall0,  m_fall[0]);
    check_eq("state0", state0, exp_state(0));
    check_eq("c_out1", c_out1, m_c[1]);
    check_eq("rise1",  rise1,  m_rise[1]);
    check_eq("fall1",  fall1,  m_fall[1]);
    check_eq("state1", state1, exp_state(1));
`ifdef SEQ_INPUT_COND_GLITCH_CNT_EN
    check_eq("glitch0", gcnt0, 8'(m_glitch[0]));
    check_eq("glitch1", gcnt1, 8'(m_glitch[1]));
`endif
  endtask

  // Apply one set of inputs across one rising edge, then compare.
  task automatic do_cycle(input bit r, input bit d, input bit e);
    rst = r; din_async = d; en = e;
    @(posedge clk);
    model_step(r, d, e);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int lat0, lat1, hold;
    bit d, e;
    rst = 1'b1; din_async = 1'b1; en = 1'b1;
    @(negedge clk);

    // Reset with din high: level stays low, no pulses.
    repeat (3) do_cycle(1'b1, 1'b1, 1'b1);
    check_eq("rst_c_out", c_out0, 1'b0);
    check_eq("rst_state", state0, 2'b00);
    do_cycle(1'b0, 1'b0, 1'b1);
    repeat (6) do_cycle(1'b0, 1'b0, 1'b1);

    // Clean rise: count edges from the din change until each c_out rises.
    lat0 = -1; lat1 = -1;
    for (int i = 1; i <= 20; i++) begin
      do_cycle(1'b0, 1'b1, 1'b1);
      if (c_out0 && lat0 < 0) lat0 = i;
      if (c_out1 && lat1 < 0) lat1 = i;
    end
    check_eq("rise_latency_dc4", 8'(lat0), 8'd6);
    check_eq("rise_latency_dc1", 8'(lat1), 8'd3);

    // Short glitch on the way back down is rejected.
    do_cycle(1'b1, 1'b0, 1'b1);
    repeat (5) do_cycle(1'b0, 1'b0, 1'b1);
    repeat (2) do_cycle(1'b0, 1'b1, 1'b1);
    repeat (8) do_cycle(1'b0, 1'b0, 1'b1);
    check_eq("glitch_c_out", c_out0, 1'b0);

    // Enable gating: din high with en low holds the level.
    repeat (20) do_cycle(1'b0, 1'b1, 1'b0);
    check_eq("gated_c_out", c_out0, 1'b0);
    repeat (6) do_cycle(1'b0, 1'b1, 1'b1);
    check_eq("ungated_c_out", c_out0, 1'b1);

    // Fall interrupted by reset after two mismatching edges.
    repeat (4) do_cycle(1'b0, 1'b0, 1'b1);
    do_cycle(1'b1, 1'b0, 1'b1);
    check_eq("rst_mid_fall", fall0, 1'b0);

    // DEBOUNCE_CYCLES=1 instance follows a 4-cycle toggle.
    for (int t = 0; t < 8; t++) repeat (4) do_cycle(1'b0, t[0], 1'b1);

    // Randomised run lengths, occasional enable drops and resets.
    d = 1'b0;
    for (int i = 0; i < 400; i++) begin
      d = ~d;
      hold = $urandom_range(1, 8);
      for (int j = 0; j < hold; j++) begin
        e = ($urandom_range(0, 9) != 0);
        do_cycle(($urandom_range(0, 199) == 0), d, e);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
